// File: rtl/gray_counter.sv
// gray_counter: registered WIDTH-bit up/down counter that presents its count in both
// binary and reflected-binary Gray code. The Gray register is loaded from the same
// next-state value as the binary register, so the two outputs always correspond.
// Priority per edge: rst > load > en > hold.
module gray_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ResetBin  = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ResetGray = ResetBin ^ (ResetBin >> 1);
    localparam logic [WIDTH-1:0] AllOnes   = {WIDTH{1'b1}};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Next-state: load beats count; wrap is only raised by a counting step that rolls over.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up_dn) begin
                bin_d  = bin_q + 1'b1;
                wrap_d = (bin_q == AllOnes);
            end else begin
                bin_d  = bin_q - 1'b1;
                wrap_d = (bin_q == '0);
            end
        end
        // Encode from the next binary value so gray_q lands on the same edge as bin_q.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= ResetBin;
            gray_q <= ResetGray;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count looks at the live direction, not en, so it can gate a
    // downstream decision before the step is taken.
    always_comb begin
        tc = up_dn ? (bin_q == AllOnes) : (bin_q == '0);
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule
